bridge_cmd_engine: RTL and testbench
====================================

Name: bridge_cmd_engine

Overview:
Parametrised successor to the fixed 4-word bridge command driver. It terminates the APF bridge host-command and core-command register windows, and exposes a host→core command channel (cmd_*) and a core→host request channel (req_*). Parameter/response windows are PARAM_WORDS deep with configurable offsets. The core request path has a ready/valid handshake and an optional watchdog. It sits on the bridge bus beside slot/data-table logic in core_top.

Parameters:
HOST_BASE, 32'hF800_0000, host command register address
CORE_BASE, 32'hF800_1000, core command register address
PARAM_OFFSET, 32'h0000_0020, offset of parameter window from each base
RESP_OFFSET, 32'h0000_0040, offset of response window from each base
PARAM_WORDS, 4, 32-bit words per parameter/response block (1..8)
TIMEOUT_CYCLES, 24'd10_000_000, watchdog limit (only with macro)

Ports:
clk  in  1  bridge clock
reset_n  in  1  asynchronous active-low reset
bridge_addr  in  32  bridge address
bridge_wr  in  1  write strobe
bridge_wr_data  in  32  write data
bridge_rd  in  1  read strobe
bridge_rd_data  out  32  read data
bridge_rd_data_valid  out  1  read data valid
cmd_valid  out  1  host command pending
cmd_word  out  16  host command code
cmd_param  out  32*PARAM_WORDS  host parameters, word 0 in LSBs
cmd_progress  in  16  busy progress
cmd_done  in  1  one-cycle completion
cmd_result  in  16  result code
cmd_response  in  32*PARAM_WORDS  response words
req_valid  in  1  core request
req_ready  out  1  request accepted when valid&ready
req_word  in  16  request code
req_param  in  32*PARAM_WORDS  request parameters
req_progress  out  16  latest "bu" progress
req_done  out  1  one-cycle completion pulse
req_result  out  16  result code
req_response  out  32*PARAM_WORDS  host response words
req_timeout  out  1  one-cycle watchdog pulse

Behaviour:
- Decode on addr[26:0]. Base+0: command/status. Base+4: PARAM_OFFSET. Base+8: RESP_OFFSET. Base+OFFSET+4*i, i<PARAM_WORDS: window word i. All other addresses, including i>=PARAM_WORDS, read 32'hFFFF_FFFF.
- Reads: bridge_rd_data registered. bridge_rd_data_valid = bridge_rd delayed exactly 1 cycle.
- Host window access: host params are write-only; host response is read-only.
- Core window access: core params are read-only; core response is write-only; core command register reads the core_cmd readback.
- Host FSM H_IDLE→H_VALID→H_DONE→H_IDLE.
  - H_IDLE: a write of {"CM",w} to HOST_BASE latches cmd_word=w and cmd_param=host params, sets status={"BU",0}, goes to H_VALID. Writes without "CM" are ignored.
  - H_VALID: cmd_valid=1. Each cycle, status={"BU",cmd_progress}. On cmd_done, status={"OK",cmd_result}, latch response, go to H_DONE.
  - Host command writes outside H_IDLE are ignored.
- Core FSM R_IDLE→R_WAIT_ACK→R_WAIT_DONE→R_DONE→R_IDLE.
  - req_ready=1 only in R_IDLE.
  - Accept: core_cmd={"cm",req_word}, latch req_param.
  - R_WAIT_ACK: a bridge write to CORE_BASE copies wr_data into core_cmd and moves to R_WAIT_DONE.
  - R_WAIT_DONE: status "bu" updates req_progress. Status "ok" latches req_result and req_response, goes to R_DONE.
  - R_DONE: req_done=1 for one cycle.
  - Core command writes in R_IDLE are ignored.
- Reset values: all FSMs idle. All status, readback, progress, result and response regs = 0. All outputs 0, except bridge_rd_data = 0.
- Simultaneous cmd_done and host write: the write is ignored. req_valid during R_DONE: not accepted until R_IDLE.
- Reset mid-transaction: abandoned, no done pulse.

Optional Feature:
BRIDGE_CMD_TIMEOUT_EN:
- Enabled: 24-bit counter runs in R_WAIT_ACK/R_WAIT_DONE and clears on each CORE_BASE write. At TIMEOUT_CYCLES-1 it forces R_DONE with req_result=16'hFFFF, req_response=0, core_cmd=0, and pulses req_timeout together with req_done.
- Disabled: no counter, FSM waits indefinitely, req_timeout tied 0.

Decomposition:
- bridge_pkg holds:
  - host and core state enums
  - ASCII tags CM/cm/BU/OK/bu/ok
  - register offsets REG_CMD=0, REG_PARAM_PTR=4, REG_RESP_PTR=8
  - TIMEOUT_RESULT=16'hFFFF
- One sub-module, bridge_param_window: a PARAM_WORDS×32 register array with decode and hit/index output. Instantiated four times: host param, host resp, core param, core resp.

Test Plan:
- Write params 1,2,3,4 then 0x434D_0042 to HOST_BASE → cmd_valid, cmd_word=0x0042, cmd_param={4,3,2,1}. Read HOST_BASE → 0x4255_0000.
- Drive cmd_progress=7, then cmd_done with result 0x0003 and response {D,C,B,A} → status 0x4F4B_0003. Response reads 0xA..0xD at +0x40..+0x4C. cmd_valid drops.
- req_valid word 0x0010 → one-cycle handshake. CORE_BASE reads 0x636D_0010. Host writes 0x6275_0005 → req_progress=5. Host writes 0x6F6B_0001 → req_done for 1 cycle, req_result=1.
- PARAM_WORDS=2: read of PARAM_OFFSET+8 → 0xFFFF_FFFF. Any read → rd_data_valid exactly 1 cycle later.
- With macro and TIMEOUT_CYCLES=16: accept a request with no host write → req_done and req_timeout at cycle 16, req_result=0xFFFF.
- Assert reset_n low in R_WAIT_DONE → all outputs 0 and req_ready=1 after release, with no req_done pulse.

Source files
------------

// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared states, ASCII tags and register offsets for the bridge command engine
package bridge_pkg;

    localparam logic [1:0] H_IDLE  = 2'd0;
    localparam logic [1:0] H_VALID = 2'd1;
    localparam logic [1:0] H_DONE  = 2'd2;

    localparam logic [1:0] R_IDLE      = 2'd0;
    localparam logic [1:0] R_WAIT_ACK  = 2'd1;
    localparam logic [1:0] R_WAIT_DONE = 2'd2;
    localparam logic [1:0] R_DONE      = 2'd3;

    // Upper-case tags belong to the host command window, lower-case to the core window.
    localparam logic [15:0] TAG_HOST_CM = 16'h434D;
    localparam logic [15:0] TAG_HOST_BU = 16'h4255;
    localparam logic [15:0] TAG_HOST_OK = 16'h4F4B;
    localparam logic [15:0] TAG_CORE_CM = 16'h636D;
    localparam logic [15:0] TAG_CORE_BU = 16'h6275;
    localparam logic [15:0] TAG_CORE_OK = 16'h6F6B;

    localparam logic [26:0] REG_CMD       = 27'd0;
    localparam logic [26:0] REG_PARAM_PTR = 27'd4;
    localparam logic [26:0] REG_RESP_PTR  = 27'd8;

    localparam logic [15:0] TIMEOUT_RESULT = 16'hFFFF;

endpackage

// File: rtl/bridge_param_window.sv
// rtl/bridge_param_window.sv - WORDS x 32 register window with address decode and bulk load
module bridge_param_window #(
    parameter logic [26:0] BASE  = 27'd0,
    parameter int          WORDS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [26:0]           addr,
    input  logic                  wr_en,
    input  logic [31:0]           wr_data,
    input  logic                  load,
    input  logic [32*WORDS-1:0]   load_data,
    output logic [32*WORDS-1:0]   words,
    output logic                  hit,
    output logic [31:0]           rd_word
);

    logic [31:0] mem [WORDS];
    logic [26:0] rel;
    logic [2:0]  idx;

    // Addresses below BASE wrap to large values and fall outside the window.
    assign rel = addr - BASE;
    assign hit = (rel[1:0] == 2'b00) && (rel < 27'(4 * WORDS));
    assign idx = rel[4:2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                if (load)
                    mem[i] <= load_data[i*32 +: 32];
                else if (wr_en && hit && idx == 3'(i))
                    mem[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx == 3'(i)) rd_word = mem[i];
        end
    end

    for (genvar g = 0; g < WORDS; g++) begin : g_flat
        assign words[g*32 +: 32] = mem[g];
    end

endmodule

// File: rtl/bridge_cmd_engine.sv
// rtl/bridge_cmd_engine.sv - APF bridge host/core command engine (optional watchdog: BRIDGE_CMD_TIMEOUT_EN)
module bridge_cmd_engine
    import bridge_pkg::*;
#(
    parameter logic [31:0] HOST_BASE      = 32'hF800_0000,
    parameter logic [31:0] CORE_BASE      = 32'hF800_1000,
    parameter logic [31:0] PARAM_OFFSET   = 32'h0000_0020,
    parameter logic [31:0] RESP_OFFSET    = 32'h0000_0040,
    parameter int          PARAM_WORDS    = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [31:0]                 bridge_addr,
    input  logic                        bridge_wr,
    input  logic [31:0]                 bridge_wr_data,
    input  logic                        bridge_rd,
    output logic [31:0]                 bridge_rd_data,
    output logic                        bridge_rd_data_valid,
    output logic                        cmd_valid,
    output logic [15:0]                 cmd_word,
    output logic [32*PARAM_WORDS-1:0]   cmd_param,
    input  logic [15:0]                 cmd_progress,
    input  logic                        cmd_done,
    input  logic [15:0]                 cmd_result,
    input  logic [32*PARAM_WORDS-1:0]   cmd_response,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [15:0]                 req_word,
    input  logic [32*PARAM_WORDS-1:0]   req_param,
    output logic [15:0]                 req_progress,
    output logic                        req_done,
    output logic [15:0]                 req_result,
    output logic [32*PARAM_WORDS-1:0]   req_response,
    output logic                        req_timeout
);

    localparam logic [26:0] HB = HOST_BASE[26:0];
    localparam logic [26:0] CB = CORE_BASE[26:0];
    localparam logic [26:0] PO = PARAM_OFFSET[26:0];
    localparam logic [26:0] RO = RESP_OFFSET[26:0];

    logic [26:0] addr;
    logic        host_cmd_wr, core_cmd_wr;
    logic [1:0]  h_state, r_state;
    logic [31:0] host_status, core_cmd, rd_mux;
    logic        host_done_evt, accept, waiting, wd_expire;

    logic [32*PARAM_WORDS-1:0] hp_words, hr_words, cp_words, cr_words;
    logic        hp_hit, hr_hit, cp_hit, cr_hit;
    logic [31:0] hp_rd_word, hr_rd_word, cp_rd_word, cr_rd_word;

    assign addr          = bridge_addr[26:0];
    assign host_cmd_wr   = bridge_wr && (addr == HB + REG_CMD);
    assign core_cmd_wr   = bridge_wr && (addr == CB + REG_CMD);
    assign host_done_evt = (h_state == H_VALID) && cmd_done;
    assign accept        = (r_state == R_IDLE) && req_valid;
    assign waiting       = (r_state == R_WAIT_ACK) || (r_state == R_WAIT_DONE);

    assign cmd_valid = (h_state == H_VALID);
    assign req_ready = (r_state == R_IDLE) && reset_n;
    assign req_done  = (r_state == R_DONE);

    bridge_param_window #(.BASE(HB + PO), .WORDS(PARAM_WORDS)) u_host_param (
        .clk(clk), .reset_n(reset_n), .addr(addr), .wr_en(bridge_wr), .wr_data(bridge_wr_data),
        .load(1'b0), .load_data('0), .words(hp_words), .hit(hp_hit), .rd_word(hp_rd_word)
    );

    bridge_param_window #(.BASE(HB + RO), .WORDS(PARAM_WORDS)) u_host_resp (
        .clk(clk), .reset_n(reset_n), .addr(addr), .wr_en(1'b0), .wr_data(bridge_wr_data),
        .load(host_done_evt), .load_data(cmd_response), .words(hr_words), .hit(hr_hit), .rd_word(hr_rd_word)
    );

    bridge_param_window #(.BASE(CB + PO), .WORDS(PARAM_WORDS)) u_core_param (
        .clk(clk), .reset_n(reset_n), .addr(addr), .wr_en(1'b0), .wr_data(bridge_wr_data),
        .load(accept), .load_data(req_param), .words(cp_words), .hit(cp_hit), .rd_word(cp_rd_word)
    );

    bridge_param_window #(.BASE(CB + RO), .WORDS(PARAM_WORDS)) u_core_resp (
        .clk(clk), .reset_n(reset_n), .addr(addr), .wr_en(bridge_wr), .wr_data(bridge_wr_data),
        .load(1'b0), .load_data('0), .words(cr_words), .hit(cr_hit), .rd_word(cr_rd_word)
    );

    // Host param and core response windows are write-only from the bridge side.
    logic unused_ok;
    assign unused_ok = ^{bridge_addr[31:27], hp_hit, hp_rd_word, cr_hit, cr_rd_word,
                         hr_words, cp_words, TIMEOUT_CYCLES};

    always_comb begin
        rd_mux = 32'hFFFF_FFFF;
        if (addr == HB + REG_CMD)            rd_mux = host_status;
        else if (addr == HB + REG_PARAM_PTR) rd_mux = PARAM_OFFSET;
        else if (addr == HB + REG_RESP_PTR)  rd_mux = RESP_OFFSET;
        else if (hr_hit)                     rd_mux = hr_rd_word;
        else if (addr == CB + REG_CMD)       rd_mux = core_cmd;
        else if (addr == CB + REG_PARAM_PTR) rd_mux = PARAM_OFFSET;
        else if (addr == CB + REG_RESP_PTR)  rd_mux = RESP_OFFSET;
        else if (cp_hit)                     rd_mux = cp_rd_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bridge_rd_data       <= '0;
            bridge_rd_data_valid <= 1'b0;
        end else begin
            bridge_rd_data_valid <= bridge_rd;
            if (bridge_rd) bridge_rd_data <= rd_mux;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_state     <= H_IDLE;
            host_status <= '0;
            cmd_word    <= '0;
            cmd_param   <= '0;
        end else begin
            case (h_state)
                H_IDLE: begin
                    if (host_cmd_wr && bridge_wr_data[31:16] == TAG_HOST_CM) begin
                        cmd_word    <= bridge_wr_data[15:0];
                        cmd_param   <= hp_words;
                        host_status <= {TAG_HOST_BU, 16'h0000};
                        h_state     <= H_VALID;
                    end
                end
                H_VALID: begin
                    if (cmd_done) begin
                        host_status <= {TAG_HOST_OK, cmd_result};
                        h_state     <= H_DONE;
                    end else begin
                        host_status <= {TAG_HOST_BU, cmd_progress};
                    end
                end
                default: h_state <= H_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= R_IDLE;
            core_cmd     <= '0;
            req_progress <= '0;
            req_result   <= '0;
            req_response <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (req_valid) begin
                        core_cmd <= {TAG_CORE_CM, req_word};
                        r_state  <= R_WAIT_ACK;
                    end
                end
                R_WAIT_ACK: begin
                    if (core_cmd_wr) begin
                        core_cmd <= bridge_wr_data;
                        r_state  <= R_WAIT_DONE;
                    end
                end
                R_WAIT_DONE: begin
                    if (core_cmd[31:16] == TAG_CORE_BU) begin
                        req_progress <= core_cmd[15:0];
                    end else if (core_cmd[31:16] == TAG_CORE_OK) begin
                        req_result   <= core_cmd[15:0];
                        req_response <= cr_words;
                        r_state      <= R_DONE;
                    end
                    if (core_cmd_wr) core_cmd <= bridge_wr_data;
                end
                default: r_state <= R_IDLE;
            endcase
            // Watchdog expiry overrides whatever the host reported this cycle.
            if (wd_expire) begin
                r_state      <= R_DONE;
                req_result   <= TIMEOUT_RESULT;
                req_response <= '0;
                core_cmd     <= '0;
            end
        end
    end

`ifdef BRIDGE_CMD_TIMEOUT_EN
    logic [23:0] wd_cnt;
    logic        to_flag;

    assign wd_expire   = waiting && !core_cmd_wr && (wd_cnt == TIMEOUT_CYCLES - 24'd1);
    assign req_timeout = to_flag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            to_flag <= wd_expire;
            if (!waiting || core_cmd_wr) wd_cnt <= '0;
            else                         wd_cnt <= wd_cnt + 24'd1;
        end
    end
`else
    assign wd_expire   = 1'b0 & waiting;
    assign req_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bridge_cmd_engine.sv
// tb/tb_bridge_cmd_engine.sv - self-checking bench for bridge_cmd_engine
module tb_bridge_cmd_engine;

    localparam int          PW = 4;
    localparam logic [23:0] TO = 24'd16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [31:0]       bridge_addr = '0;
    logic              bridge_wr = 1'b0;
    logic [31:0]       bridge_wr_data = '0;
    logic              bridge_rd = 1'b0;
    logic [31:0]       bridge_rd_data;
    logic              bridge_rd_data_valid;
    logic              cmd_valid;
    logic [15:0]       cmd_word;
    logic [32*PW-1:0]  cmd_param;
    logic [15:0]       cmd_progress = '0;
    logic              cmd_done = 1'b0;
    logic [15:0]       cmd_result = '0;
    logic [32*PW-1:0]  cmd_response = '0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [15:0]       req_word = '0;
    logic [32*PW-1:0]  req_param = '0;
    logic [15:0]       req_progress;
    logic              req_done;
    logic [15:0]       req_result;
    logic [32*PW-1:0]  req_response;
    logic              req_timeout;

    always #5 clk = ~clk;

    bridge_cmd_engine #(.PARAM_WORDS(PW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .bridge_addr(bridge_addr), .bridge_wr(bridge_wr), .bridge_wr_data(bridge_wr_data),
        .bridge_rd(bridge_rd), .bridge_rd_data(bridge_rd_data), .bridge_rd_data_valid(bridge_rd_data_valid),
        .cmd_valid(cmd_valid), .cmd_word(cmd_word), .cmd_param(cmd_param),
        .cmd_progress(cmd_progress), .cmd_done(cmd_done), .cmd_result(cmd_result), .cmd_response(cmd_response),
        .req_valid(req_valid), .req_ready(req_ready), .req_word(req_word), .req_param(req_param),
        .req_progress(req_progress), .req_done(req_done), .req_result(req_result),
        .req_response(req_response), .req_timeout(req_timeout)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]      m_hparam [PW];
    logic [31:0]      m_hresp  [PW];
    logic [31:0]      m_cparam [PW];
    logic [31:0]      m_cresp  [PW];
    int               h_phase = 0;
    int               c_phase = 0;
    int               m_t = 0;
    logic [31:0]      m_hstatus = '0;
    logic [31:0]      m_core_cmd = '0;
    logic [15:0]      m_cmd_word = '0;
    logic [15:0]      m_prog = '0;
    logic [15:0]      m_result = '0;
    logic [32*PW-1:0] m_cmd_param = '0;
    logic [32*PW-1:0] m_req_resp = '0;
    logic             m_rv = 1'b0;
    logic [31:0]      m_rd = '0;
    logic             m_to = 1'b0;

    function automatic int win(input logic [31:0] a, input logic [31:0] base);
        logic [26:0] r;
        r = a[26:0] - base[26:0];
        if (r[1:0] == 2'b00 && r < 27'(4 * PW)) return int'(r >> 2);
        return -1;
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a);
        logic [26:0] x;
        x = a[26:0];
        if (x == 27'h0)          return m_hstatus;
        if (x == 27'h4)          return 32'h20;
        if (x == 27'h8)          return 32'h40;
        if (win(a, 32'h40) >= 0) return m_hresp[win(a, 32'h40)];
        if (x == 27'h1000)       return m_core_cmd;
        if (x == 27'h1004)       return 32'h20;
        if (x == 27'h1008)       return 32'h40;
        if (win(a, 32'h1020) >= 0) return m_cparam[win(a, 32'h1020)];
        return 32'hFFFF_FFFF;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        int c_prev;
        logic [31:0] old_cmd;
        logic host_w, core_w;
        if (!reset_n) begin
            for (int i = 0; i < PW; i++) begin
                m_hparam[i] = '0; m_hresp[i] = '0; m_cparam[i] = '0; m_cresp[i] = '0;
            end
            h_phase = 0; c_phase = 0; m_t = 0;
            m_hstatus = '0; m_core_cmd = '0; m_cmd_word = '0; m_prog = '0; m_result = '0;
            m_cmd_param = '0; m_req_resp = '0; m_rv = 1'b0; m_rd = '0; m_to = 1'b0;
        end else begin
            host_w = bridge_wr && bridge_addr[26:0] == 27'h0;
            core_w = bridge_wr && bridge_addr[26:0] == 27'h1000;
            c_prev = c_phase;
            m_rv = bridge_rd;
            if (bridge_rd) m_rd = mread(bridge_addr);
            m_to = 1'b0;
            case (h_phase)
                0: if (host_w && bridge_wr_data[31:16] == 16'h434D) begin
                    m_cmd_word = bridge_wr_data[15:0];
                    for (int i = 0; i < PW; i++) m_cmd_param[i*32 +: 32] = m_hparam[i];
                    m_hstatus = 32'h4255_0000;
                    h_phase = 1;
                end
                1: if (cmd_done) begin
                    m_hstatus = {16'h4F4B, cmd_result};
                    for (int i = 0; i < PW; i++) m_hresp[i] = cmd_response[i*32 +: 32];
                    h_phase = 2;
                end else begin
                    m_hstatus = {16'h4255, cmd_progress};
                end
                default: h_phase = 0;
            endcase
            case (c_phase)
                0: if (req_valid) begin
                    m_core_cmd = {16'h636D, req_word};
                    for (int i = 0; i < PW; i++) m_cparam[i] = req_param[i*32 +: 32];
                    c_phase = 1;
                end
                1: if (core_w) begin
                    m_core_cmd = bridge_wr_data;
                    c_phase = 2;
                end
                2: begin
                    old_cmd = m_core_cmd;
                    if (old_cmd[31:16] == 16'h6275) m_prog = old_cmd[15:0];
                    else if (old_cmd[31:16] == 16'h6F6B) begin
                        m_result = old_cmd[15:0];
                        for (int i = 0; i < PW; i++) m_req_resp[i*32 +: 32] = m_cresp[i];
                        c_phase = 3;
                    end
                    if (core_w) m_core_cmd = bridge_wr_data;
                end
                default: c_phase = 0;
            endcase
`ifdef BRIDGE_CMD_TIMEOUT_EN
            if (c_prev == 1 || c_prev == 2) begin
                if (core_w) m_t = 0;
                else if (m_t == int'(TO) - 1) begin
                    c_phase = 3; m_result = 16'hFFFF; m_req_resp = '0; m_core_cmd = '0; m_to = 1'b1;
                end else m_t++;
            end else m_t = 0;
`endif
            if (bridge_wr && win(bridge_addr, 32'h20) >= 0)   m_hparam[win(bridge_addr, 32'h20)] = bridge_wr_data;
            if (bridge_wr && win(bridge_addr, 32'h1040) >= 0) m_cresp[win(bridge_addr, 32'h1040)] = bridge_wr_data;
        end
    end

    always @(negedge clk) begin
        chk("rd_valid", bridge_rd_data_valid, m_rv);
        if (m_rv) chk("rd_data", bridge_rd_data, m_rd);
        chk("cmd_valid", cmd_valid, h_phase == 1);
        chk("cmd_word", cmd_word, m_cmd_word);
        chk("cmd_param", cmd_param, m_cmd_param);
        chk("req_ready", req_ready, reset_n && c_phase == 0);
        chk("req_done", req_done, c_phase == 3);
        chk("req_progress", req_progress, m_prog);
        chk("req_result", req_result, m_result);
        chk("req_response", req_response, m_req_resp);
        chk("req_timeout", req_timeout, m_to);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bridge_addr = a; bridge_wr_data = d; bridge_wr = 1'b1;
        tick();
        bridge_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bridge_addr = a; bridge_rd = 1'b1;
        tick();
        bridge_rd = 1'b0;
        d = bridge_rd_data;
    endtask

    initial begin : stim
        logic [31:0] d;
        int n;
        repeat (3) tick();
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rd_data", bridge_rd_data, 0);
        chk("rst_cmd_param", cmd_param, 0);
        reset_n = 1'b1;
        tick();
        chk("ready_after_reset", req_ready, 1);

        bus_write(32'hF800_0000, 32'h1234_0099);
        chk("non_cm_ignored", cmd_valid, 0);
        for (int i = 0; i < 4; i++) bus_write(32'hF800_0020 + 32'(4 * i), 32'(i + 1));
        bus_write(32'hF800_0000, 32'h434D_0042);
        chk("cmd_valid_set", cmd_valid, 1);
        chk("cmd_word_lit", cmd_word, 16'h0042);
        chk("cmd_param_lit", cmd_param, 128'h00000004_00000003_00000002_00000001);
        bus_read(32'hF800_0000, d);
        chk("status_bu0", d, 32'h4255_0000);

        cmd_progress = 16'd7;
        tick();
        bus_read(32'hF800_0000, d);
        chk("status_bu7", d, 32'h4255_0007);
        bus_write(32'hF800_0000, 32'h434D_0099);
        chk("busy_write_ignored", cmd_word, 16'h0042);

        cmd_done = 1'b1; cmd_result = 16'h0003;
        cmd_response = {32'hD, 32'hC, 32'hB, 32'hA};
        bus_write(32'hF800_0000, 32'h434D_0055);
        cmd_done = 1'b0;
        chk("cmd_valid_drop", cmd_valid, 0);
        tick();
        chk("done_write_ignored", cmd_word, 16'h0042);
        bus_read(32'hF800_0000, d);
        chk("status_ok", d, 32'h4F4B_0003);
        for (int i = 0; i < 4; i++) begin
            bus_read(32'hF800_0040 + 32'(4 * i), d);
            chk("host_resp", d, 32'(10 + i));
        end
        bus_read(32'hF800_0004, d);  chk("param_ptr", d, 32'h20);
        bus_read(32'hF800_0008, d);  chk("resp_ptr", d, 32'h40);
        bus_read(32'hF800_0050, d);  chk("resp_oob", d, 32'hFFFF_FFFF);
        bus_read(32'hF800_0020, d);  chk("hparam_wo", d, 32'hFFFF_FFFF);
        bus_read(32'hF800_0100, d);  chk("unmapped", d, 32'hFFFF_FFFF);

        req_word = 16'h0010;
        req_param = {32'h44, 32'h33, 32'h22, 32'h11};
        req_valid = 1'b1;
        chk("req_ready_idle", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("req_ready_busy", req_ready, 0);
        bus_read(32'hF800_1000, d);  chk("core_cmd_cm", d, 32'h636D_0010);
        bus_read(32'hF800_1024, d);  chk("core_param1", d, 32'h22);
        for (int i = 0; i < 4; i++) bus_write(32'hF800_1040 + 32'(4 * i), 32'h100 + 32'(i));
        bus_write(32'hF800_1000, 32'h6275_0005);
        tick();
        chk("req_progress_lit", req_progress, 16'd5);
        bus_write(32'hF800_1000, 32'h6F6B_0001);
        chk("req_done_early", req_done, 0);
        req_valid = 1'b1; req_word = 16'h0020;
        tick();
        chk("req_done_lit", req_done, 1);
        chk("req_result_lit", req_result, 16'd1);
        chk("req_resp_lit", req_response, 128'h00000103_00000102_00000101_00000100);
        chk("ready_in_done", req_ready, 0);
        tick();
        chk("req_done_one", req_done, 0);
        chk("ready_back", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("accepted_after_done", req_ready, 0);

        bus_write(32'hF800_1000, 32'h6275_0009);
        tick();
        chk("req_progress_9", req_progress, 16'd9);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_progress", req_progress, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_done", req_done, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_ready", req_ready, 1);
        repeat (4) tick();
        bus_write(32'hF800_1000, 32'h6F6B_0077);
        bus_read(32'hF800_1000, d);
        chk("idle_core_write_ignored", d, 32'h0);

        req_word = 16'h0030; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
`ifdef BRIDGE_CMD_TIMEOUT_EN
        n = 0;
        while (!req_done && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_pulse", req_timeout, 1);
        chk("timeout_result", req_result, 16'hFFFF);
        chk("timeout_resp", req_response, 0);
`else
        n = 0;
        repeat (40) begin
            tick();
            n += int'(req_done);
        end
        chk("no_watchdog_done", n, 0);
        chk("no_watchdog_timeout", req_timeout, 0);
        bus_write(32'hF800_1000, 32'h6F6B_0004);
        tick();
        chk("late_done", req_done, 1);
        chk("late_result", req_result, 16'd4);
`endif
        repeat (2) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
